// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces three raw coin sensors
// and turns each stable insertion into exactly one single-cycle output pulse.
// Pulses go out on nickel/dime/quarter for a clean single-sensor coin. A coin
// seen on several sensors, or inserted while the controller is inhibited,
// produces a pulse on reject instead.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic coin_n_raw,
    input  logic coin_d_raw,
    input  logic coin_q_raw,
    input  logic inhibit,
    output logic nickel,
    output logic dime,
    output logic quarter,
    output logic reject,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        WAIT_RELEASE
    } state_t;

    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Two-flop synchroniser; sync_p1 is the only sensor view the FSM uses.
    // Bit order is {q, d, n}.
    logic [2:0] sync_p0;
    logic [2:0] sync_p1;

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] snap;

    // True when exactly one sensor is active.
    function automatic logic is_one_hot(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    // Synchronise the asynchronous sensor levels into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= 3'b000;
            sync_p1 <= 3'b000;
        end else begin
            sync_p0 <= {coin_q_raw, coin_d_raw, coin_n_raw};
            sync_p1 <= sync_p0;
        end
    end

    // Debounce FSM with registered pulse outputs and registered busy flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            snap    <= 3'b000;
            nickel  <= 1'b0;
            dime    <= 1'b0;
            quarter <= 1'b0;
            reject  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            nickel  <= 1'b0;
            dime    <= 1'b0;
            quarter <= 1'b0;
            reject  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_p1 != 3'b000) begin
                        snap  <= sync_p1;
                        cnt   <= 8'd1;
                        state <= DEBOUNCE;
                        busy  <= 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (sync_p1 != snap) begin
                        // Sensor set moved before it settled: drop it and rescan.
                        state <= IDLE;
                        cnt   <= 8'd0;
                        busy  <= 1'b0;
                    end else if (cnt == LAST) begin
                        // Outputs are loaded on the edge entering EMIT so they
                        // are high for exactly the EMIT cycle; inhibit is taken
                        // at that same edge.
                        state <= EMIT;
                        if (inhibit || !is_one_hot(snap)) begin
                            reject <= 1'b1;
                        end else begin
                            nickel  <= snap[0];
                            dime    <= snap[1];
                            quarter <= snap[2];
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                EMIT: begin
                    state <= WAIT_RELEASE;
                    cnt   <= 8'd0;
                end
                WAIT_RELEASE: begin
                    // Need DEBOUNCE_CYCLES consecutive quiet samples before
                    // another coin can start, so a held coin pulses once.
                    if (sync_p1 != 3'b000) begin
                        cnt <= 8'd0;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
